vga_bounce_renderer: RTL and testbench



---
 rtl/vga_bounce_renderer.sv | 171 +++++++++++++++++
 tb/tb_vga_bounce_renderer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_bounce_renderer.sv
//----------------------------------------------------------------------------
// vga_bounce_renderer
//   Pixel stage between the VGA timing generator and the PMOD output mapping.
//   Draws a solid box that bounces around the visible area over a
//   checkerboard. Every output is registered, so there is exactly one clk
//   of latency from the timing inputs to the pixel and sync outputs.
//
// Ports
//   clk, rst_n          pixel clock, async active-low reset
//   hsync_in/vsync_in   syncs from the timing generator
//   display_on          high inside the visible area
//   hpos/vpos           current pixel coordinate
//   speed               pixels moved per frame on each axis (0 = frozen)
//   hsync_out/vsync_out syncs delayed one clk to line up with r/g/b
//   r/g/b               2-bit colour channels
//   frame_tick          one-clk pulse at the start of each vsync pulse
//----------------------------------------------------------------------------
`timescale 1ns/1ps

// One bounce axis: position plus direction, stepped once per frame tick.
// o_hit is the "this tick reaches an edge" flag used for the colour change.
module vga_bounce_axis #(
  parameter int MAX = 608
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_step,
  input  logic [2:0] i_speed,
  output logic [9:0] o_pos,
  output logic       o_hit
);
  logic [9:0]  r_pos;
  logic        r_dir;    // 1 = moving towards MAX
  logic [10:0] w_sum;    // 11 bits so pos+speed never wraps
  logic [9:0]  w_nxt;
  logic        w_edge;

  always_comb begin
    w_sum  = {1'b0, r_pos} + {8'd0, i_speed};
    w_edge = 1'b0;
    w_nxt  = r_pos;
    if (r_dir) begin
      w_edge = (w_sum >= 11'(MAX));
      w_nxt  = w_edge ? 10'(MAX) : w_sum[9:0];
    end else begin
      w_edge = (r_pos <= {7'd0, i_speed});
      w_nxt  = w_edge ? 10'd0 : (r_pos - {7'd0, i_speed});
    end
  end

  assign o_hit = w_edge && (i_speed != 3'd0);
  assign o_pos = r_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= 10'd0;
      r_dir <= 1'b1;
    end else if (i_step && (i_speed != 3'd0)) begin
      r_pos <= w_nxt;
      if (w_edge) r_dir <= ~r_dir;
    end
  end
endmodule

module vga_bounce_renderer #(
  parameter int   H_ACTIVE          = 640,
  parameter int   V_ACTIVE          = 480,
  parameter int   BOX_SIZE          = 32,
  parameter logic SYNC_ACTIVE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       display_on,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic [2:0] speed,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       frame_tick
);
  localparam int          NUM_AXES = 2;
  localparam int          AXIS_MAX [NUM_AXES] = '{H_ACTIVE - BOX_SIZE, V_ACTIVE - BOX_SIZE};
  localparam logic [10:0] BOX11 = 11'(BOX_SIZE);

  logic                          r_vs_q;
  logic                          r_frame_tick;
  logic                          r_hs, r_vs;
  logic [1:0]                    r_col;
  logic [5:0]                    r_rgb;

  logic [NUM_AXES-1:0][9:0]      w_pix;
  logic [NUM_AXES-1:0][9:0]      w_box;
  logic [NUM_AXES-1:0]           w_hit;
  logic [NUM_AXES-1:0]           w_in;
  logic                          w_tick_nxt;
  logic                          w_inside;
  logic                          w_chk;
  logic [5:0]                    w_rgb;

  assign w_pix = {vpos, hpos};

  genvar a;
  generate
    for (a = 0; a < NUM_AXES; a++) begin : g_axis
      vga_bounce_axis #(.MAX(AXIS_MAX[a])) u_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_step  (r_frame_tick),
        .i_speed (speed),
        .o_pos   (w_box[a]),
        .o_hit   (w_hit[a])
      );
      assign w_in[a] = ({1'b0, w_pix[a]} >= {1'b0, w_box[a]}) &&
                       ({1'b0, w_pix[a]} <  ({1'b0, w_box[a]} + BOX11));
    end
  endgenerate

  // Rising edge into the active vsync level; the history register resets to
  // inactive, so a vsync already active at reset release still yields a tick.
  assign w_tick_nxt = (vsync_in == SYNC_ACTIVE_LEVEL) && (r_vs_q != SYNC_ACTIVE_LEVEL);

  assign w_inside = display_on && (&w_in);
  assign w_chk    = hpos[5] ^ vpos[5];

  always_comb begin
    w_rgb = 6'b00_00_00;
    if (display_on) begin
      if (w_inside) begin
        case (r_col)
          2'd0:    w_rgb = 6'b11_00_00;
          2'd1:    w_rgb = 6'b00_11_00;
          2'd2:    w_rgb = 6'b00_00_11;
          default: w_rgb = 6'b11_11_11;
        endcase
      end else begin
        w_rgb = {1'b0, w_chk, 1'b0, w_chk, 1'b0, w_chk};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_q       <= ~SYNC_ACTIVE_LEVEL;
      r_frame_tick <= 1'b0;
      r_hs         <= ~SYNC_ACTIVE_LEVEL;
      r_vs         <= ~SYNC_ACTIVE_LEVEL;
      r_col        <= 2'd0;
      r_rgb        <= 6'd0;
    end else begin
      r_vs_q       <= vsync_in;
      r_frame_tick <= w_tick_nxt;
      r_hs         <= hsync_in;
      r_vs         <= vsync_in;
      r_rgb        <= w_rgb;
      // Corner hits bump the colour only once.
      if (r_frame_tick && (|w_hit)) r_col <= r_col + 2'd1;
    end
  end

  assign hsync_out  = r_hs;
  assign vsync_out  = r_vs;
  assign frame_tick = r_frame_tick;
  assign r          = r_rgb[5:4];
  assign g          = r_rgb[3:2];
  assign b          = r_rgb[1:0];
endmodule

// File: tb/tb_vga_bounce_renderer.sv
`timescale 1ns/1ps
module tb_vga_bounce_renderer;
  localparam int XMAX = 608;
  localparam int YMAX = 448;
  localparam int BOX  = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hsync_in, vsync_in, display_on;
  logic [9:0] hpos, vpos;
  logic [2:0] speed;
  logic       hsync_out, vsync_out, frame_tick;
  logic [1:0] r, g, b;

  int n_chk = 0;
  int n_err = 0;

  // reference state: box position, direction (+1/-1), colour index
  int m_x, m_y, m_sx, m_sy, m_idx;

  vga_bounce_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
    .speed      (speed),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .r          (r),
    .g          (g),
    .b          (b),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_sx = 1; m_sy = 1; m_idx = 0;
  endtask

  // Reflect a 1-D position off [0, lim]; returns 1 if an edge was touched.
  task automatic bounce(inout int p, inout int dir, input int s, input int lim, output bit hit);
    int t;
    hit = 0;
    t = p + dir * s;
    if (t >= lim) begin p = lim; dir = -1; hit = 1; end
    else if (t <= 0) begin p = 0; dir = 1; hit = 1; end
    else p = t;
  endtask

  task automatic model_tick(input int s);
    bit hx, hy;
    if (s == 0) return;
    bounce(m_x, m_sx, s, XMAX, hx);
    bounce(m_y, m_sy, s, YMAX, hy);
    if (hx || hy) m_idx = (m_idx + 1) % 4;
  endtask

  function automatic logic [5:0] exp_pix(input bit de, input int h, input int v);
    logic [5:0] pal [4];
    int c;
    pal[0] = 6'b110000; pal[1] = 6'b001100; pal[2] = 6'b000011; pal[3] = 6'b111111;
    if (!de) return 6'd0;
    if (h >= m_x && h < m_x + BOX && v >= m_y && v < m_y + BOX) return pal[m_idx];
    c = ((h >> 5) ^ (v >> 5)) & 1;
    return (c != 0) ? 6'b010101 : 6'b000000;
  endfunction

  // One pixel: drive, clock once, compare the registered result.
  task automatic probe(input bit de, input int h, input int v);
    bit hs;
    hs = 1'($urandom);
    h = h & 1023; v = v & 1023;
    display_on = de; hpos = 10'(h); vpos = 10'(v); hsync_in = hs;
    @(posedge clk); #1;
    chk("pix", {26'd0, r, g, b}, {26'd0, exp_pix(de, h, v)});
    chk("hsync_out", {31'd0, hsync_out}, {31'd0, hs});
    chk("vsync_out", {31'd0, vsync_out}, 32'd1);
  endtask

  task automatic probe_box();
    probe(1, m_x, m_y);
    probe(1, m_x + BOX - 1, m_y + BOX - 1);
    probe(1, m_x - 1, m_y);
    probe(1, m_x + BOX, m_y);
    probe(1, m_x, m_y - 1);
    probe(1, m_x, m_y + BOX);
    probe(0, m_x + 3, m_y + 3);
    probe(1, $urandom_range(0, 639), $urandom_range(0, 479));
  endtask

  task automatic frame(input int s, input int len);
    speed = 3'(s);
    vsync_in = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      chk("frame_tick", {31'd0, frame_tick}, (i == 0) ? 32'd1 : 32'd0);
      chk("vsync_lo", {31'd0, vsync_out}, 32'd0);
    end
    vsync_in = 1'b1;
    @(posedge clk); #1;
    chk("frame_tick_off", {31'd0, frame_tick}, 32'd0);
    model_tick(s);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; display_on = 1'b1;
    hpos = 10'd10; vpos = 10'd10; speed = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsync", {31'd0, hsync_out}, 32'd1);
    chk("rst_vsync", {31'd0, vsync_out}, 32'd1);
    chk("rst_rgb", {26'd0, r, g, b}, 32'd0);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    // vsync held active across release: history is inactive, so one tick
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_tick", {31'd0, frame_tick}, 32'd1);
    vsync_in = 1'b1;
    @(posedge clk); #1;
    chk("rel_tick_off", {31'd0, frame_tick}, 32'd0);

    // latency and hsync follow
    probe(1, 10, 10);
    chk("red_at_10", {26'd0, r, g, b}, 32'h30);
    probe(1, 200, 10);
    probe(1, 10, 40);

    // motion: three 2-line vsync pulses at speed 4
    for (int f = 0; f < 3; f++) frame(4, 2);
    chk("model_12", m_x * 1000 + m_y, 12012);
    probe_box();

    // drive to the right edge: x=604 -> 608 (bounce) -> 604
    for (int f = 3; f < 151; f++) begin
      frame(4, 1);
      if (f % 64 == 0) probe_box();
    end
    probe_box();
    frame(4, 1); probe_box();
    frame(4, 1); probe_box();

    // exact multiples of 4 on both axes meet at a corner on frame 2128
    for (int f = 153; f < 2127; f++) begin
      frame(4, 1);
      if (f % 97 == 0) probe_box();
    end
    probe_box();
    frame(4, 1);
    chk("corner_model", m_x * 1000 + m_y, 448);
    probe_box();
    frame(4, 1); probe_box();

    // frozen for two frames
    frame(0, 2); frame(0, 1);
    probe_box();

    // mid-line reset: output clears asynchronously
    probe(1, m_x + 5, m_y + 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rgb", {26'd0, r, g, b}, 32'd0);
    chk("async_hsync", {31'd0, hsync_out}, 32'd1);
    chk("async_tick", {31'd0, frame_tick}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    probe(1, 10, 10);
    probe_box();

    // randomized frames with probes near the box
    for (int f = 0; f < 250; f++) begin
      frame($urandom_range(0, 7), $urandom_range(1, 3));
      probe(1, m_x + $urandom_range(0, 40) - 4, m_y + $urandom_range(0, 40) - 4);
      probe(1'($urandom), $urandom_range(0, 1023), $urandom_range(0, 1023));
      if (f % 25 == 0) probe_box();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
